// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter
//  Shares one ALU and its srcA/srcB operand muxes between two requesters
//  (req 0 = execute stage, req 1 = debug/address-generation unit). Each cycle
//  the arbiter grants at most one request. It steers the winner's mux selects
//  and alu_fun to the ALU, and captures the ALU result into a 1-entry
//  response buffer.
//
//  Optional feature: define ALU_ARB_LOCK_EN to enable the req 0 burst lock.
//  While the lock is set, only req 0 is granted and the pointer is frozen at 0.
//  Without the macro, req_lock is ignored.
//
//  Ports
//   CLK, RST_N             clock; synchronous active-low reset
//   req_valid/req_ready    per-requester handshake (req_ready is a one-hot grant)
//   req_fun/srcA/srcB      per-requester ALU function and operand selects
//   req_lock               req 0 burst lock request
//   alu_srcA/srcB/fun      steered to the operand muxes and the ALU
//   alu_result             combinational ALU result for the current selects
//   rsp_valid/id/data      response buffer contents; rsp_ready drains it
module alu_share_arbiter #(
   parameter int unsigned WIDTH   = 32,
   parameter int unsigned FUN_W   = 4,
   parameter int unsigned RR_EN   = 1,
   parameter int unsigned RR_INIT = 0
) (
   input  logic               CLK,
   input  logic               RST_N,
   input  logic [1:0]         req_valid,
   output logic [1:0]         req_ready,
   input  logic [2*FUN_W-1:0] req_fun,
   input  logic [3:0]         req_srcA,
   input  logic [3:0]         req_srcB,
   input  logic               req_lock,
   output logic [1:0]         alu_srcA,
   output logic [1:0]         alu_srcB,
   output logic [FUN_W-1:0]   alu_fun,
   input  logic [WIDTH-1:0]   alu_result,
   output logic               rsp_valid,
   output logic               rsp_id,
   output logic [WIDTH-1:0]   rsp_data,
   input  logic               rsp_ready
);

   typedef enum logic {
      S_EMPTY = 1'b0,
      S_FULL  = 1'b1
   } state_t;

   state_t             state_q, state_d;
   logic               ptr_q, ptr_d;
   logic               rsp_id_q, rsp_id_d;
   logic [WIDTH-1:0]   rsp_data_q, rsp_data_d;
   logic               lock_active;
   logic [1:0]         elig;
   logic               can_issue;
   logic               grant;
   logic               win;

`ifdef ALU_ARB_LOCK_EN
   logic               lock_q, lock_d;
   assign lock_active = lock_q;
`else
   logic               unused_req_lock;
   assign unused_req_lock = req_lock;
   assign lock_active     = 1'b0;
`endif

   // Arbitration and steering of the winner's selects onto the ALU
   always_comb begin
      req_ready = 2'b00;
      alu_srcA  = 2'b00;
      alu_srcB  = 2'b00;
      alu_fun   = '0;
      win       = 1'b0;

      // A locked burst hides req 1 from arbitration entirely
      elig      = {req_valid[1] & ~lock_active, req_valid[0]};
      // Grants are suppressed under reset so nothing is handshaken that reset discards
      can_issue = RST_N & ((state_q == S_EMPTY) | rsp_ready);
      grant     = can_issue & (|elig);

      if (elig == 2'b11) begin
         win = (RR_EN != 0) ? ptr_q : 1'b0;
      end else begin
         win = ~elig[0];
      end

      if (grant) begin
         req_ready[win] = 1'b1;
         alu_srcA       = win ? req_srcA[3:2] : req_srcA[1:0];
         alu_srcB       = win ? req_srcB[3:2] : req_srcB[1:0];
         alu_fun        = win ? req_fun[2*FUN_W-1:FUN_W] : req_fun[FUN_W-1:0];
      end
   end

   // Buffer FSM, response capture, pointer and lock update
   always_comb begin
      state_d    = state_q;
      rsp_id_d   = rsp_id_q;
      rsp_data_d = rsp_data_q;
      ptr_d      = ptr_q;
`ifdef ALU_ARB_LOCK_EN
      lock_d     = lock_q;
`endif

      case (state_q)
         S_EMPTY: if (grant) state_d = S_FULL;
         S_FULL:  if (rsp_ready && !grant) state_d = S_EMPTY;
         default: state_d = S_EMPTY;
      endcase

      if (grant) begin
         rsp_id_d   = win;
         rsp_data_d = alu_result;
         ptr_d      = ~win;
      end

`ifdef ALU_ARB_LOCK_EN
      if (grant && !win) lock_d = req_lock;
      // Pointer parks on req 0 for the whole locked burst
      if (lock_d) ptr_d = 1'b0;
`endif
   end

   // State registers with synchronous reset
   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         state_q    <= S_EMPTY;
         ptr_q      <= 1'(RR_INIT);
         rsp_id_q   <= 1'b0;
         rsp_data_q <= '0;
`ifdef ALU_ARB_LOCK_EN
         lock_q     <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         rsp_id_q   <= rsp_id_d;
         rsp_data_q <= rsp_data_d;
`ifdef ALU_ARB_LOCK_EN
         lock_q     <= lock_d;
`endif
      end
   end

   assign rsp_valid = (state_q == S_FULL);
   assign rsp_id    = rsp_id_q;
   assign rsp_data  = rsp_data_q;

endmodule
